// File: rtl/ssl_pkg.sv
// ----------------------------------------------------------------------------
// ssl_pkg
// Shared definitions for the sound-source-localisation direction-of-arrival
// estimator:
//   - default frame length / lag width / physical lag limit
//   - width of a signed delay word (lag width + 1 sign bit)
//   - FSM state encoding of the estimator
//   - sector width
// ----------------------------------------------------------------------------
package ssl_pkg;

    // Default correlation frame length (power of two) and derived lag width.
    localparam int NDATA_DEFAULT     = 128;
    localparam int NDATA_LOG_DEFAULT = $clog2(NDATA_DEFAULT);

    // Largest physically meaningful |delay| in samples for the mic geometry.
    localparam int MAXLAG_DEFAULT    = 20;

    // A signed delay needs one bit more than a lag index so that the full
    // index range [0, NDATA-1] maps to [-NDATA/2, NDATA/2-1] without wrap.
    localparam int DEL_W_DEFAULT     = NDATA_LOG_DEFAULT + 1;

    // Earliest-arrival sector code: 0=ref, 1=A, 2=B, 3=C.
    localparam int SECTOR_W          = 2;

    // Estimator control states. Encoding is fixed so the debug port value
    // is stable across builds.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MED  = 2'd1,
        ST_DEC  = 2'd2,
        ST_OUT  = 2'd3
    } fsm_state_e;

endpackage : ssl_pkg

// File: rtl/median3.sv
// ----------------------------------------------------------------------------
// median3
// Combinational signed median of three values.
//
// Ports
//   a, b, c : in  W signed  the three samples (order irrelevant)
//   y       : out W signed  the median value
// ----------------------------------------------------------------------------
module median3
    import ssl_pkg::*;
#(
    parameter int W = DEL_W_DEFAULT
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic signed [W-1:0] c,
    output logic signed [W-1:0] y
);

    logic signed [W-1:0] lo_ab;
    logic signed [W-1:0] hi_ab;
    logic signed [W-1:0] hi_c;

    // median(a,b,c) = max(min(a,b), min(max(a,b), c))
    always_comb begin
        lo_ab = (a < b) ? a : b;
        hi_ab = (a < b) ? b : a;
        hi_c  = (hi_ab < c) ? hi_ab : c;
        y     = (lo_ab > hi_c) ? lo_ab : hi_c;
    end

endmodule : median3

// File: rtl/doa_estimator.sv
// ----------------------------------------------------------------------------
// doa_estimator
// Turns the per-frame peak-lag indices of three cross-correlation arrays
// (mic A/B/C against the reference mic) into median-filtered signed delays,
// an earliest-arrival sector and an in-range flag.
//
// Ports
//   clk       : in  1            rising-edge clock
//   rst       : in  1            synchronous active-high reset
//   ena       : in  1            global enable; low holds all state
//   cntin     : in  NDATA_LOG    master sample counter
//   dIdA/B/C  : in  NDATA_LOG    peak-lag indices, valid when cntin==NDATA-1
//   dReady    : in  1            consumer ready
//   dValid    : out 1            result valid
//   dSector   : out 2            earliest mic: 0=ref, 1=A, 2=B, 3=C
//   dDelA/B/C : out NDATA_LOG+1  signed median-filtered delays
//   dInRange  : out 1            all three delays within +/-MAXLAG
//   dOvf      : out 1            sticky: a frame arrived while busy
//   fsm_state : out 2            current control state (debug)
//
// Output handshake: a result is transferred on a cycle where dValid and
// dReady are both high. Once dValid rises, dValid and every result output
// stay constant until that transfer; dValid may not drop without it (only
// reset discards a pending result). dReady may change freely.
// ----------------------------------------------------------------------------
module doa_estimator
    import ssl_pkg::*;
#(
    parameter int NDATA     = NDATA_DEFAULT,
    parameter int NDATA_LOG = $clog2(NDATA),
    parameter int MAXLAG    = MAXLAG_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  logic [NDATA_LOG-1:0]        cntin,
    input  logic [NDATA_LOG-1:0]        dIdA,
    input  logic [NDATA_LOG-1:0]        dIdB,
    input  logic [NDATA_LOG-1:0]        dIdC,
    input  logic                        dReady,
    output logic                        dValid,
    output logic [SECTOR_W-1:0]         dSector,
    output logic signed [NDATA_LOG:0]   dDelA,
    output logic signed [NDATA_LOG:0]   dDelB,
    output logic signed [NDATA_LOG:0]   dDelC,
    output logic                        dInRange,
    output logic                        dOvf,
    output logic [1:0]                  fsm_state
);

    localparam int DW = NDATA_LOG + 1;

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] MED  = ST_MED;
    localparam logic [1:0] DEC  = ST_DEC;
    localparam logic [1:0] OUT  = ST_OUT;

    localparam logic [NDATA_LOG-1:0] LAST_CNT = NDATA_LOG'(NDATA - 1);
    localparam logic signed [DW-1:0] HALF     = DW'(NDATA / 2);
    localparam logic signed [DW-1:0] LAG_MAX  = DW'(MAXLAG);
    localparam logic signed [DW-1:0] LAG_MIN  = -LAG_MAX;

    // ------------------------------------------------------------------
    // Frame strobe and lag-to-delay conversion
    // ------------------------------------------------------------------
    logic                 strobe;
    logic signed [DW-1:0] conv [3];

    assign strobe = ena && (cntin == LAST_CNT);

    // Zero-extend the index by one bit before subtracting so index 0 lands
    // on -NDATA/2 and index NDATA-1 on NDATA/2-1; no saturation needed.
    always_comb begin
        conv[0] = $signed({1'b0, dIdA}) - HALF;
        conv[1] = $signed({1'b0, dIdB}) - HALF;
        conv[2] = $signed({1'b0, dIdC}) - HALF;
    end

    // ------------------------------------------------------------------
    // Per-channel 3-deep history (slot 0 newest) and median filters
    // ------------------------------------------------------------------
    logic signed [DW-1:0] hist     [3][3];
    logic signed [DW-1:0] med_comb [3];
    logic signed [DW-1:0] med_q    [3];

    for (genvar ch = 0; ch < 3; ch++) begin : g_med
        median3 #(.W(DW)) u_median3 (
            .a (hist[ch][0]),
            .b (hist[ch][1]),
            .c (hist[ch][2]),
            .y (med_comb[ch])
        );
    end

    // ------------------------------------------------------------------
    // Decision logic on the registered medians
    // ------------------------------------------------------------------
    logic                any_neg;
    logic [SECTOR_W-1:0] sector_c;
    logic                in_range_c;

    always_comb begin
        any_neg    = med_q[0][DW-1] | med_q[1][DW-1] | med_q[2][DW-1];
        in_range_c = 1'b1;
        for (int ch = 0; ch < 3; ch++) begin
            if (med_q[ch] < LAG_MIN || med_q[ch] > LAG_MAX) begin
                in_range_c = 1'b0;
            end
        end
        // Most negative median wins; "<=" gives A priority over B and C,
        // and B over C, when medians tie.
        if (!any_neg) begin
            sector_c = 2'd0;
        end else if (med_q[0] <= med_q[1] && med_q[0] <= med_q[2]) begin
            sector_c = 2'd1;
        end else if (med_q[1] <= med_q[2]) begin
            sector_c = 2'd2;
        end else begin
            sector_c = 2'd3;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------
    logic [1:0] state;

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dValid   <= 1'b0;
            dSector  <= '0;
            dDelA    <= '0;
            dDelB    <= '0;
            dDelC    <= '0;
            dInRange <= 1'b1;
            dOvf     <= 1'b0;
            for (int ch = 0; ch < 3; ch++) begin
                med_q[ch] <= '0;
                for (int s = 0; s < 3; s++) begin
                    hist[ch][s] <= '0;
                end
            end
        end else begin
            // The output transfer is not gated by ena so a consumer can
            // always drain a finished result.
            if (state == OUT && dValid && dReady) begin
                dValid <= 1'b0;
                state  <= IDLE;
            end else if (ena) begin
                case (state)
                    IDLE: begin
                        if (strobe) begin
                            for (int ch = 0; ch < 3; ch++) begin
                                hist[ch][2] <= hist[ch][1];
                                hist[ch][1] <= hist[ch][0];
                                hist[ch][0] <= conv[ch];
                            end
                            state <= MED;
                        end
                    end
                    MED: begin
                        for (int ch = 0; ch < 3; ch++) begin
                            med_q[ch] <= med_comb[ch];
                        end
                        state <= DEC;
                    end
                    DEC: begin
                        dDelA    <= med_q[0];
                        dDelB    <= med_q[1];
                        dDelC    <= med_q[2];
                        dSector  <= sector_c;
                        dInRange <= in_range_c;
                        dValid   <= 1'b1;
                        state    <= OUT;
                    end
                    default: begin
                        // OUT: waiting for the consumer.
                        state <= state;
                    end
                endcase
            end

            // Any strobe outside IDLE is a dropped frame, including one that
            // lands on the very cycle of the output transfer.
            if (strobe && state != IDLE) begin
                dOvf <= 1'b1;
            end
        end
    end

endmodule : doa_estimator

// File: tb/tb_doa_estimator.sv
// ----------------------------------------------------------------------------
// tb_doa_estimator
// Directed self-checking bench for doa_estimator (NDATA=128, MAXLAG=20).
// ----------------------------------------------------------------------------
module tb_doa_estimator;

    localparam int NL = 7;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MED  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 ena;
    logic [NL-1:0]        cntin;
    logic [NL-1:0]        dIdA, dIdB, dIdC;
    logic                 dReady;
    logic                 dValid;
    logic [1:0]           dSector;
    logic signed [NL:0]   dDelA, dDelB, dDelC;
    logic                 dInRange;
    logic                 dOvf;
    logic [1:0]           fsm_state;

    int n_checks = 0;
    int n_pass   = 0;

    doa_estimator dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .cntin     (cntin),
        .dIdA      (dIdA),
        .dIdB      (dIdB),
        .dIdC      (dIdC),
        .dReady    (dReady),
        .dValid    (dValid),
        .dSector   (dSector),
        .dDelA     (dDelA),
        .dDelB     (dDelB),
        .dDelC     (dDelC),
        .dInRange  (dInRange),
        .dOvf      (dOvf),
        .fsm_state (fsm_state)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock; inputs change and outputs are sampled 1 ns after
    // the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One strobe cycle carrying the given lag indices.
    task automatic strobe(input int a, input int b, input int c);
        dIdA  = NL'(a);
        dIdB  = NL'(b);
        dIdC  = NL'(c);
        cntin = 7'd127;
        tick();
        cntin = 7'd0;
    endtask

    // Strobe and walk to the result: dValid low for two cycles after the
    // strobe edge, high on the third.
    task automatic frame(input int a, input int b, input int c);
        strobe(a, b, c);
        check("valid_lat1", dValid, 0);
        tick();
        check("valid_lat2", dValid, 0);
        tick();
        check("valid_lat3", dValid, 1);
    endtask

    // Consume the result (dReady must be high).
    task automatic ack();
        tick();
        check("ack_valid", dValid, 0);
        check("ack_state", fsm_state, S_IDLE);
    endtask

    task automatic check_out(input int a, input int b, input int c,
                             input int sec, input int inr);
        check("del_a", dDelA, a);
        check("del_b", dDelB, b);
        check("del_c", dDelC, c);
        check("sector", dSector, sec);
        check("in_range", dInRange, inr);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst    = 1'b1;
        ena    = 1'b1;
        cntin  = '0;
        dIdA   = 7'd64;
        dIdB   = 7'd64;
        dIdC   = 7'd64;
        dReady = 1'b1;

        // Reset values.
        do_reset();
        check("rst_valid", dValid, 0);
        check("rst_ovf", dOvf, 0);
        check("rst_state", fsm_state, S_IDLE);
        check_out(0, 0, 0, 0, 1);

        // Centred lags for three frames.
        for (int f = 0; f < 3; f++) begin
            frame(64, 64, 64);
            check_out(0, 0, 0, 0, 1);
            ack();
        end

        // A=54 (-10), B=70 (+6), C=64 (0) from reset.
        do_reset();
        frame(54, 70, 64);
        check_out(0, 0, 0, 0, 1);
        ack();
        frame(54, 70, 64);
        check_out(-10, 6, 0, 1, 1);
        ack();

        // Outlier rejection: A lags 60, 100, 60 -> -4, 36, -4.
        do_reset();
        frame(60, 64, 64);
        ack();
        frame(100, 64, 64);
        check("outlier_f2", dDelA, 0);
        ack();
        frame(60, 64, 64);
        check_out(-4, 0, 0, 1, 1);
        ack();

        // Out of range: A=10 (-54).
        do_reset();
        frame(10, 64, 64);
        check_out(0, 0, 0, 0, 1);
        ack();
        frame(10, 64, 64);
        check_out(-54, 0, 0, 1, 0);
        ack();
        frame(10, 64, 64);
        check_out(-54, 0, 0, 1, 0);
        ack();

        // Range edges: +20 / -20 inside, +21 outside; B most negative.
        do_reset();
        frame(84, 44, 64);
        ack();
        frame(84, 44, 64);
        check_out(20, -20, 0, 2, 1);
        ack();
        frame(85, 44, 64);
        ack();
        frame(85, 44, 64);
        check_out(21, -20, 0, 2, 0);
        ack();

        // Index extremes: 0 -> -64, 127 -> +63.
        do_reset();
        frame(0, 127, 64);
        ack();
        frame(0, 127, 64);
        check_out(-64, 63, 0, 1, 0);
        ack();

        // Ties and sector C.
        do_reset();
        frame(64, 50, 50);
        ack();
        frame(64, 50, 50);
        check_out(0, -14, -14, 2, 1);
        ack();
        do_reset();
        frame(60, 60, 40);
        ack();
        frame(60, 60, 40);
        check_out(-4, -4, -24, 3, 0);
        ack();
        do_reset();
        frame(40, 64, 40);
        ack();
        frame(40, 64, 40);
        check_out(-24, 0, -24, 1, 0);
        ack();

        // Overflow: strobe while OUT is held, history must not change.
        do_reset();
        dReady = 1'b0;
        frame(44, 64, 64);
        check("ovf_before", dOvf, 0);
        strobe(10, 64, 64);
        check("ovf_set", dOvf, 1);
        check("ovf_hold_valid", dValid, 1);
        check("ovf_hold_state", fsm_state, S_OUT);
        check_out(0, 0, 0, 0, 1);
        tick();
        check("ovf_hold2", dValid, 1);
        dReady = 1'b1;
        ack();
        frame(64, 64, 64);
        check("ovf_hist1", dDelA, 0);
        ack();
        frame(44, 64, 64);
        check("ovf_hist2", dDelA, -20);
        check("ovf_sector", dSector, 1);
        check("ovf_sticky", dOvf, 1);
        ack();

        // Strobe on the handshake cycle is dropped, no re-entry.
        do_reset();
        dReady = 1'b0;
        frame(64, 64, 64);
        dReady = 1'b1;
        strobe(30, 64, 64);
        check("coin_valid", dValid, 0);
        check("coin_state", fsm_state, S_IDLE);
        check("coin_ovf", dOvf, 1);
        tick();
        check("coin_no_reentry", fsm_state, S_IDLE);

        // Enable low: no strobe, FSM holds mid-flight, handshake completes.
        do_reset();
        ena = 1'b0;
        strobe(10, 64, 64);
        check("ena_nostrobe", fsm_state, S_IDLE);
        ena = 1'b1;
        strobe(64, 64, 64);
        check("ena_med", fsm_state, S_MED);
        ena = 1'b0;
        tick();
        tick();
        check("ena_hold_state", fsm_state, S_MED);
        check("ena_hold_valid", dValid, 0);
        ena = 1'b1;
        tick();
        tick();
        check("ena_resume", dValid, 1);
        ena = 1'b0;
        tick();
        check("ena_ack_valid", dValid, 0);
        check("ena_ack_state", fsm_state, S_IDLE);
        ena = 1'b1;

        // Reset while a result is pending in OUT.
        dReady = 1'b0;
        frame(54, 30, 64);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_out_valid", dValid, 0);
        check("rst_out_state", fsm_state, S_IDLE);
        check("rst_out_ovf", dOvf, 0);
        check_out(0, 0, 0, 0, 1);
        dReady = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_doa_estimator
